// File: rtl/pattern_to_sensors_v0_if.sv
// rtl/pattern_to_sensors_v0_if.sv - upstream FIFO read and downstream FIFO write signals
interface pattern_to_sensors_v0_if;
    logic [255:0] MSTREAM32;
    logic         empty;
    logic         valid;
    logic         rd_en;
    logic [63:0]  DO;
    logic         valid_fifo;

    modport master (
        input  MSTREAM32, empty, valid,
        output rd_en, DO, valid_fifo
    );

    modport slave (
        output MSTREAM32, empty, valid,
        input  rd_en, DO, valid_fifo
    );
endinterface

// File: rtl/pattern_to_sensors_v0.sv
// rtl/pattern_to_sensors_v0.sv - 256-bit word to four 64-bit slices with sensor lanes
// Optional macro SENSOR_STREAM_EN: Num_Pat hold per slice and registered MSTREAMOUT lanes.
module pattern_to_sensors_v0 (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [7:0]                   Num_Pat,
    input  logic                         stream_en_i,
    output logic                         stream_en_o,
    output logic [20:1]                  MSTREAMOUT,
    pattern_to_sensors_v0_if.master      bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_OUT} state_t;

    state_t        state_q, state_d;
    logic [255:0]  data_q, data_d;
    logic [1:0]    slice_q, slice_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    hold_q, hold_d;
    logic [7:0]    hold_sample;
    logic          rd_en_q, rd_en_d;
    logic          vf_q, vf_d;
    logic          se_q, se_d;
    logic [63:0]   do_q, do_d;
    logic [19:0]   mso_q, mso_d;
    logic          fetch_ok;

    assign fetch_ok = stream_en_i && !bus.empty;

`ifdef SENSOR_STREAM_EN
    assign hold_sample = (Num_Pat == 8'd0) ? 8'd1 : Num_Pat;
`else
    logic unused_num_pat;
    assign unused_num_pat = ^Num_Pat;
    assign hold_sample    = 8'd1;
`endif

    // Most significant slice goes out first so downstream width converters keep write order.
    function automatic logic [63:0] slice_of(input logic [255:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    slice_of = w[255:192];
            2'd1:    slice_of = w[191:128];
            2'd2:    slice_of = w[127:64];
            default: slice_of = w[63:0];
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        slice_d = slice_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        do_d    = do_q;
        vf_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fetch_ok) state_d = S_REQ;
            end
            S_REQ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.valid) begin
                    data_d  = bus.MSTREAM32;
                    slice_d = 2'd0;
                    cnt_d   = 8'd0;
                    hold_d  = hold_sample;
                    do_d    = bus.MSTREAM32[255:192];
                    vf_d    = 1'b1;
                    state_d = S_OUT;
                end
            end
            default: begin
                if (cnt_q == hold_q - 8'd1) begin
                    cnt_d = 8'd0;
                    if (slice_q == 2'd3) begin
                        state_d = fetch_ok ? S_REQ : S_IDLE;
                    end else begin
                        slice_d = slice_q + 2'd1;
                        do_d    = slice_of(data_q, slice_q + 2'd1);
                        vf_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        endcase
        // Registered outputs track the next state so they line up with it cycle for cycle.
        rd_en_d = (state_d == S_REQ);
        se_d    = (state_d == S_OUT);
`ifdef SENSOR_STREAM_EN
        mso_d   = (state_d == S_OUT) ? do_d[19:0] : mso_q;
`else
        mso_d   = 20'd0;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            slice_q <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            rd_en_q <= 1'b0;
            vf_q    <= 1'b0;
            se_q    <= 1'b0;
            do_q    <= '0;
            mso_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            slice_q <= slice_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            rd_en_q <= rd_en_d;
            vf_q    <= vf_d;
            se_q    <= se_d;
            do_q    <= do_d;
            mso_q   <= mso_d;
        end
    end

    assign bus.rd_en      = rd_en_q;
    assign bus.valid_fifo = vf_q;
    assign bus.DO         = do_q;
    assign stream_en_o    = se_q;
    assign MSTREAMOUT     = mso_q;
endmodule

// File: tb/tb_pattern_to_sensors_v0.sv
// tb/tb_pattern_to_sensors_v0.sv - directed vector bench for pattern_to_sensors_v0
module tb_pattern_to_sensors_v0;
`ifdef SENSOR_STREAM_EN
    localparam bit STREAM_EN = 1'b1;
`else
    localparam bit STREAM_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [7:0]  Num_Pat;
    logic        stream_en_i;
    logic        stream_en_o;
    logic [20:1] MSTREAMOUT;

    pattern_to_sensors_v0_if bus ();

    pattern_to_sensors_v0 dut (
        .clk         (clk),
        .reset       (reset),
        .Num_Pat     (Num_Pat),
        .stream_en_i (stream_en_i),
        .stream_en_o (stream_en_o),
        .MSTREAMOUT  (MSTREAMOUT),
        .bus         (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0]        np;
        logic [255:0]      data;
        logic [3:0][63:0]  exp_do;
        logic [3:0][19:0]  exp_mso;
        int                gap_en;
    } vec_t;

    vec_t vecs [5];

    int checks;
    int errors;
    int cyc;
    int vf_cyc [$];
    logic [63:0] vf_do [$];
    logic [19:0] vf_mso [$];
    int rd_cyc [$];
    int se_rise;
    logic se_prev;
    logic [19:0] mso_at [int];
    logic [63:0] do_at [int];
    logic        vf_at [int];
    logic [255:0] fifo_mem [0:7];
    int fifo_wr;
    int fifo_rd;
    bit pending;

    // Upstream FIFO model with one-cycle read latency plus output logging.
    initial begin
        cyc = 0; pending = 0; se_prev = 0; se_rise = 0;
        fifo_wr = 0; fifo_rd = 0;
        bus.valid = 1'b0; bus.empty = 1'b1; bus.MSTREAM32 = '0;
        forever begin
            @(negedge clk);
            cyc++;
            mso_at[cyc] = MSTREAMOUT;
            do_at[cyc]  = bus.DO;
            vf_at[cyc]  = bus.valid_fifo;
            if (bus.valid_fifo) begin
                vf_cyc.push_back(cyc);
                vf_do.push_back(bus.DO);
                vf_mso.push_back(MSTREAMOUT);
            end
            if (bus.rd_en) rd_cyc.push_back(cyc);
            if (stream_en_o && !se_prev) se_rise++;
            se_prev = stream_en_o;
            bus.valid = 1'b0;
            if (pending && fifo_rd < fifo_wr) begin
                bus.valid = 1'b1;
                bus.MSTREAM32 = fifo_mem[fifo_rd];
                fifo_rd++;
            end
            pending = 0;
            if (bus.rd_en && reset) pending = 1;
            bus.empty = (fifo_rd + (pending ? 1 : 0)) >= fifo_wr;
        end
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        vf_cyc.delete(); vf_do.delete(); vf_mso.delete(); rd_cyc.delete();
        se_rise = 0;
        fifo_wr = 0; fifo_rd = 0;
        bus.empty = 1'b1;
    endtask

    task automatic load(input logic [255:0] w);
        fifo_mem[fifo_wr] = w;
        fifo_wr++;
        bus.empty = 1'b0;
    endtask

    task automatic wait_vf(input string name, input int n, input int lim);
        int k;
        k = 0;
        while (vf_cyc.size() < n && k < lim) begin
            step(1);
            k++;
        end
        if (vf_cyc.size() < n) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d pulses expected %0d", name, vf_cyc.size(), n);
        end
    endtask

    initial begin
        int gap;
        checks = 0; errors = 0;
        reset = 1'b0; Num_Pat = 8'd0; stream_en_i = 1'b0;

        vecs[0].np = 8'd2;
        vecs[0].data = {64'h000fffff000eeeee, 64'h000ddddd000ccccc, 64'h000bbbbb000aaaaa, 64'h0009999900088888};
        vecs[0].exp_do = {64'h0009999900088888, 64'h000bbbbb000aaaaa, 64'h000ddddd000ccccc, 64'h000fffff000eeeee};
        vecs[0].exp_mso = {20'h88888, 20'haaaaa, 20'hccccc, 20'heeeee};
        vecs[0].gap_en = 2;
        vecs[1].np = 8'd0;
        vecs[1].data = {64'h0123456789abcdef, 64'hfedcba9876543210, 64'hdeadbeefcafef00d, 64'h5555aaaa0f0f0f0f};
        vecs[1].exp_do = {64'h5555aaaa0f0f0f0f, 64'hdeadbeefcafef00d, 64'hfedcba9876543210, 64'h0123456789abcdef};
        vecs[1].exp_mso = {20'hf0f0f, 20'hef00d, 20'h43210, 20'hbcdef};
        vecs[1].gap_en = 1;
        vecs[2].np = 8'd1;
        vecs[2].data = {64'hffffffffffffffff, 64'h0, 64'h8000000000000001, 64'h00000000000fffff};
        vecs[2].exp_do = {64'h00000000000fffff, 64'h8000000000000001, 64'h0, 64'hffffffffffffffff};
        vecs[2].exp_mso = {20'hfffff, 20'h00001, 20'h00000, 20'hfffff};
        vecs[2].gap_en = 1;
        vecs[3].np = 8'd3;
        vecs[3].data = {64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333, 64'h4444444444444444};
        vecs[3].exp_do = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
        vecs[3].exp_mso = {20'h44444, 20'h33333, 20'h22222, 20'h11111};
        vecs[3].gap_en = 3;
        vecs[4].np = 8'd5;
        vecs[4].data = {64'h0000000000012345, 64'h0000000000067890, 64'h00000000000abcde, 64'h00000000000f1234};
        vecs[4].exp_do = {64'h00000000000f1234, 64'h00000000000abcde, 64'h0000000000067890, 64'h0000000000012345};
        vecs[4].exp_mso = {20'hf1234, 20'habcde, 20'h67890, 20'h12345};
        vecs[4].gap_en = 5;

        step(2);
        chk("reset_rd_en", bus.rd_en, 0);
        chk("reset_valid_fifo", bus.valid_fifo, 0);
        chk("reset_stream_en_o", stream_en_o, 0);
        chk("reset_DO", bus.DO, 0);
        chk("reset_MSTREAMOUT", MSTREAMOUT, 0);
        reset = 1'b1;
        step(2);

        for (int i = 0; i < 5; i++) begin
            gap = STREAM_EN ? vecs[i].gap_en : 1;
            clear_log();
            Num_Pat = vecs[i].np;
            load(vecs[i].data);
            stream_en_i = 1'b1;
            wait_vf($sformatf("v%0d", i), 4, 100);
            step(gap + 6);
            stream_en_i = 1'b0;
            step(2);
            chk($sformatf("v%0d_rd_count", i), rd_cyc.size(), 1);
            chk($sformatf("v%0d_vf_count", i), vf_cyc.size(), 4);
            if (rd_cyc.size() > 0 && vf_cyc.size() > 0)
                chk($sformatf("v%0d_latency", i), vf_cyc[0] - rd_cyc[0], 2);
            for (int s = 0; s < 4; s++) begin
                if (s < vf_cyc.size()) begin
                    if (s > 0)
                        chk($sformatf("v%0d_gap_s%0d", i, s), vf_cyc[s] - vf_cyc[s-1], gap);
                    for (int j = 0; j < gap; j++) begin
                        chk($sformatf("v%0d_do_s%0d_h%0d", i, s, j), do_at[vf_cyc[s] + j], vecs[i].exp_do[s]);
                        chk($sformatf("v%0d_mso_s%0d_h%0d", i, s, j), mso_at[vf_cyc[s] + j],
                            STREAM_EN ? vecs[i].exp_mso[s] : 20'd0);
                        chk($sformatf("v%0d_vf_s%0d_h%0d", i, s, j), vf_at[vf_cyc[s] + j], (j == 0));
                    end
                end
            end
        end

        // Back-to-back words
        gap = STREAM_EN ? 2 : 1;
        clear_log();
        Num_Pat = 8'd2;
        load(vecs[0].data);
        load(vecs[3].data);
        stream_en_i = 1'b1;
        wait_vf("b2b", 8, 200);
        step(10);
        stream_en_i = 1'b0;
        step(2);
        chk("b2b_rd_count", rd_cyc.size(), 2);
        chk("b2b_vf_count", vf_cyc.size(), 8);
        chk("b2b_se_rises", se_rise, 2);
        if (rd_cyc.size() == 2 && vf_cyc.size() == 8) begin
            chk("b2b_second_rd", rd_cyc[1], vf_cyc[3] + gap);
            for (int s = 0; s < 8; s++)
                chk($sformatf("b2b_do_%0d", s), vf_do[s], (s < 4) ? vecs[0].exp_do[s] : vecs[3].exp_do[s-4]);
        end

        // Empty FIFO gates fetching
        clear_log();
        stream_en_i = 1'b1;
        step(100);
        chk("empty_rd_count", rd_cyc.size(), 0);
        chk("empty_vf_count", vf_cyc.size(), 0);
        stream_en_i = 1'b0;
        step(2);

        // stream_en_i dropped during slice 1
        clear_log();
        Num_Pat = 8'd3;
        load(vecs[1].data);
        load(vecs[2].data);
        stream_en_i = 1'b1;
        wait_vf("drop", 2, 100);
        stream_en_i = 1'b0;
        step(40);
        chk("drop_vf_count", vf_cyc.size(), 4);
        chk("drop_rd_count", rd_cyc.size(), 1);
        if (vf_cyc.size() == 4) chk("drop_do_s3", vf_do[3], vecs[1].exp_do[3]);
        chk("drop_stream_en_o", stream_en_o, 0);

        // Reset asserted mid-word
        clear_log();
        Num_Pat = 8'd4;
        load(vecs[2].data);
        load(vecs[3].data);
        stream_en_i = 1'b1;
        wait_vf("rst", 2, 100);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_rd_en", bus.rd_en, 0);
        chk("rst_valid_fifo", bus.valid_fifo, 0);
        chk("rst_stream_en_o", stream_en_o, 0);
        chk("rst_DO", bus.DO, 0);
        chk("rst_MSTREAMOUT", MSTREAMOUT, 0);
        stream_en_i = 1'b0;
        step(3);
        reset = 1'b1;
        step(20);
        chk("rst_no_more_vf", vf_cyc.size(), 2);
        stream_en_i = 1'b1;
        wait_vf("rst_resume", 6, 100);
        stream_en_i = 1'b0;
        step(30);
        chk("rst_resume_vf_count", vf_cyc.size(), 6);
        if (vf_cyc.size() >= 3) chk("rst_resume_do", vf_do[2], vecs[3].exp_do[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
